// File: rtl/gray_mem_arbiter_if.sv
// Requester and gray-memory read-port bundle for gray_mem_arbiter.
// The arbiter takes the slave view; the memory/requester side takes master.
interface gray_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic [1:0]    rq_req;
  logic [AW-1:0] rq_addr0;
  logic [AW-1:0] rq_addr1;
  logic [1:0]    rq_last;
  logic [1:0]    rq_gnt;
  logic [1:0]    rq_valid;
  logic [DW-1:0] rq_data;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic          gray_ready;
  logic [DW-1:0] gray_data;

  modport slave (
    input  rq_req, rq_addr0, rq_addr1, rq_last,
    input  gray_ready, gray_data,
    output rq_gnt, rq_valid, rq_data,
    output gray_addr, gray_req
  );

  modport master (
    output rq_req, rq_addr0, rq_addr1, rq_last,
    output gray_ready, gray_data,
    input  rq_gnt, rq_valid, rq_data,
    input  gray_addr, gray_req
  );
endinterface

// File: rtl/gray_mem_arbiter.sv
// Round-robin burst arbiter sharing the gray-image read port between two requesters.
// Define GRAY_MEM_ARB_STATS_EN to add saturating per-requester beat counters.
module gray_mem_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  gray_mem_arbiter_if.slave bus
`ifdef GRAY_MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_beats0,
  output logic [15:0] stat_beats1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    REARB
  } state_t;

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_t        state, state_n;
  logic [1:0]    gnt, gnt_n, pick;
  logic          ptr, ptr_n;
  logic [7:0]    cnt, cnt_n, cnt_inc;
  logic [AW-1:0] addr, addr_n, sel_addr;
  logic          req, req_n;
  logic          g, sel_req, sel_last;
  logic          accept, rel;
  logic          v1, t1, v2, t2;
  logic [1:0]    valid;
  logic [DW-1:0] data;

  always_comb begin
    g        = gnt[1];
    sel_req  = g ? bus.rq_req[1] : bus.rq_req[0];
    sel_last = g ? bus.rq_last[1] : bus.rq_last[0];
    sel_addr = g ? bus.rq_addr1 : bus.rq_addr0;
    cnt_inc  = cnt + 8'd1;
    accept   = (state == GRANT) && sel_req && (gnt != 2'b00);
    // without a request this is the idle release
    rel      = !sel_req || sel_last || (cnt_inc == MAXB);
    pick     = (&bus.rq_req) ? {ptr, ~ptr} : bus.rq_req;
    state_n  = state;
    gnt_n    = gnt;
    ptr_n    = ptr;
    cnt_n    = cnt;
    addr_n   = addr;
    req_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.gray_ready && (|bus.rq_req)) begin
          gnt_n   = pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          req_n  = 1'b1;
          addr_n = sel_addr;
          cnt_n  = cnt_inc;
        end
        if (rel) begin
          gnt_n   = 2'b00;
          ptr_n   = ~g;
          cnt_n   = 8'd0;
          state_n = REARB;
        end
      end
      REARB: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt   <= 2'b00;
      ptr   <= 1'b0;
      cnt   <= 8'd0;
      addr  <= '0;
      req   <= 1'b0;
      v1    <= 1'b0;
      t1    <= 1'b0;
      v2    <= 1'b0;
      t2    <= 1'b0;
      valid <= 2'b00;
      data  <= '0;
    end else begin
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      req   <= req_n;
      // tag follows the beat until its data shows up
      v1    <= accept;
      t1    <= g;
      v2    <= v1;
      t2    <= t1;
      valid <= 2'b00;
      if (v2) begin
        valid <= t2 ? 2'b10 : 2'b01;
        data  <= bus.gray_data;
      end
    end
  end

  assign bus.rq_gnt    = gnt;
  assign bus.rq_valid  = valid;
  assign bus.rq_data   = data;
  assign bus.gray_addr = addr;
  assign bus.gray_req  = req;

`ifdef GRAY_MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_beats0 <= 16'd0;
      stat_beats1 <= 16'd0;
    end else if (accept) begin
      if (!g && stat_beats0 != 16'hFFFF)
        stat_beats0 <= stat_beats0 + 16'd1;
      if (g && stat_beats1 != 16'hFFFF)
        stat_beats1 <= stat_beats1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Scoreboard bench for gray_mem_arbiter: burst-list requesters, memory model,
// transaction-level grant predictor and a decoupled rq_valid monitor.
module tb_gray_mem_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gray_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef GRAY_MEM_ARB_STATS_EN
  logic [15:0] stat_beats0, stat_beats1;
`endif

  gray_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef GRAY_MEM_ARB_STATS_EN
    ,
    .stat_beats0(stat_beats0),
    .stat_beats1(stat_beats1)
`endif
  );

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    int who;
    int n;
  } gr_t;

  logic [DW-1:0] mem [1<<AW];
  exp_t sbq[$];
  gr_t  gq[$];
  int   bl0[$];
  int   bl1[$];
  int   base[2];
  int   off[2];
  int   pos[2];
  int   stat_m[2];
  int   mptr;
  int   n_pass = 0;
  int   n_tot = 0;
  int   cyc = 0;
  logic [DW-1:0] last_data = '0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // memory: data valid the cycle after gray_req, noise otherwise
  always @(posedge clk) begin
    if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];
    else              bus.gray_data <= DW'($urandom);
  end

  task automatic check(input string name, input int act,
                       input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_data = '0;
    end else if (bus.rq_valid != 2'b00) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'(bus.rq_valid), 0);
      end else begin
        mon_e = sbq.pop_front();
        check("valid_tag", 32'(bus.rq_valid),
              mon_e.tag == 1 ? 2 : 1);
        check("valid_data", 32'(bus.rq_data), 32'(mon_e.data));
        check("valid_latency", cyc, mon_e.due);
      end
      last_data = bus.rq_data;
    end else begin
      check("data_hold", 32'(bus.rq_data), 32'(last_data));
    end
  end

  // round robin over burst lists, each grant capped at MAXB beats
  task automatic build_grants();
    int c0[$];
    int c1[$];
    int p;
    int n;
    c0 = bl0;
    c1 = bl1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) p = mptr;
      else p = (c0.size() > 0) ? 0 : 1;
      if (p == 0) begin
        n = (c0[0] < MAXB) ? c0[0] : MAXB;
        c0[0] -= n;
        if (c0[0] == 0) void'(c0.pop_front());
      end else begin
        n = (c1[0] < MAXB) ? c1[0] : MAXB;
        c1[0] -= n;
        if (c1[0] == 0) void'(c1.pop_front());
      end
      gq.push_back('{p, n});
      mptr = 1 - p;
    end
  endtask

  task automatic setup(input int b0, input int b1);
    base[0] = b0;
    base[1] = b1;
    off = '{0, 0};
    pos = '{0, 0};
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(bus.rq_gnt), 0);
    check({tag, "_valid"}, 32'(bus.rq_valid), 0);
    check({tag, "_data"}, 32'(bus.rq_data), 0);
    check({tag, "_gaddr"}, 32'(bus.gray_addr), 0);
    check({tag, "_greq"}, 32'(bus.gray_req), 0);
`ifdef GRAY_MEM_ARB_STATS_EN
    check({tag, "_stat0"}, 32'(stat_beats0), 0);
    check({tag, "_stat1"}, 32'(stat_beats1), 0);
`endif
  endtask

  task automatic run(input int ready_pct, input int hold,
                     input int abort_after, input bit exact_gap);
    logic [1:0]    g, prev_gnt, rq, ls;
    logic [AW-1:0] ad[2];
    logic [AW-1:0] exp_addr;
    logic          rdy, prev_ready, exp_req;
    int            hd[2];
    int            gap, beats, acc;
    bit            first, done;
    build_grants();
    prev_gnt = 2'b00;
    prev_ready = 1'b0;
    exp_req = 1'b0;
    exp_addr = '0;
    gap = 0;
    beats = 0;
    acc = 0;
    first = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (exp_req) begin
        check("gray_req", 32'(bus.gray_req), 1);
        check("gray_addr", 32'(bus.gray_addr), 32'(exp_addr));
      end else begin
        check("gray_req_idle", 32'(bus.gray_req), 0);
      end
      g = bus.rq_gnt;
      if (g == 2'b11) check("gnt_onehot", 32'(g), 1);
      if (k < hold) check("hold_gnt", 32'(g), 0);
      if (prev_gnt == 2'b00 && g != 2'b00) begin
        check("grant_ready", 32'(prev_ready), 1);
        if (gq.size() == 0) check("grant_extra", 32'(g), 0);
        else check("grant_who", 32'(g), gq[0].who == 1 ? 2 : 1);
        if (!first) begin
          if (exact_gap) check("grant_gap", gap, 2);
          else check("grant_gap_min", 32'(gap >= 2), 1);
        end
        first = 1'b0;
        beats = 0;
      end
      if (prev_gnt != 2'b00 && g != 2'b00 && g != prev_gnt)
        check("grant_switch", 32'(g), 32'(prev_gnt));
      if (prev_gnt != 2'b00 && g == 2'b00) begin
        if (gq.size() > 0) begin
          check("grant_beats", beats, gq[0].n);
          void'(gq.pop_front());
        end
        gap = 0;
      end
      if (g == 2'b00) gap++;
      if (bl0.size() == 0 && bl1.size() == 0 && g == 2'b00 &&
          sbq.size() == 0 && k >= hold) begin
        done = 1'b1;
      end else begin
        rdy = (k < hold) ? 1'b0 :
              1'(int'($urandom_range(99)) < ready_pct);
        hd[0] = (bl0.size() > 0) ? bl0[0] : 0;
        hd[1] = (bl1.size() > 0) ? bl1[0] : 0;
        for (int i = 0; i < 2; i++) begin
          rq[i] = (hd[i] > 0);
          ad[i] = rq[i] ? AW'(base[i] + off[i]) : AW'($urandom);
          ls[i] = rq[i] ? (pos[i] == hd[i] - 1) : 1'($urandom);
        end
        bus.rq_req = rq;
        bus.rq_addr0 = ad[0];
        bus.rq_addr1 = ad[1];
        bus.rq_last = ls;
        bus.gray_ready = rdy;
        exp_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (g[i] && rq[i]) begin
            sbq.push_back('{i, mem[ad[i]], cyc + 3});
            exp_req = 1'b1;
            exp_addr = ad[i];
            beats++;
            acc++;
            off[i]++;
            pos[i]++;
            stat_m[i]++;
            if (pos[i] == hd[i]) begin
              pos[i] = 0;
              if (i == 0) void'(bl0.pop_front());
              else void'(bl1.pop_front());
            end
          end
        end
        prev_gnt = g;
        prev_ready = rdy;
        if (abort_after > 0 && acc >= abort_after) return;
      end
    end
    if (!done) begin
      check("timeout", 0, 1);
    end else begin
      check("grants_left", gq.size(), 0);
`ifdef GRAY_MEM_ARB_STATS_EN
      check("stat0", 32'(stat_beats0), stat_m[0]);
      check("stat1", 32'(stat_beats1), stat_m[1]);
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    bus.rq_req = 2'b00;
    bus.rq_addr0 = '0;
    bus.rq_addr1 = '0;
    bus.rq_last = 2'b00;
    bus.gray_ready = 1'b0;
    mptr = 0;
    stat_m = '{0, 0};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // single beat from requester 0
    setup(14'h0081, 0);
    bl0 = '{1};
    run(100, 0, 0, 1'b1);

    // two 9-beat bursts each, alternating grants
    setup(14'h0100, 14'h2000);
    bl0 = '{9, 9};
    bl1 = '{9, 9};
    run(100, 0, 0, 1'b1);

    // a 20-beat burst split at the burst cap
    setup(14'h0400, 14'h3000);
    bl0 = '{20};
    bl1 = '{3, 3};
    run(100, 0, 0, 1'b1);

    // random burst mixes with a stalling memory
    for (int r = 0; r < 3; r++) begin
      setup(int'($urandom_range(16383)), int'($urandom_range(16383)));
      repeat ($urandom_range(1, 4)) bl0.push_back($urandom_range(1, 40));
      repeat ($urandom_range(0, 4)) bl1.push_back($urandom_range(1, 40));
      run(60, 0, 0, 1'b0);
    end

    // reset with two beats in flight
    setup(14'h1234, 0);
    bl0 = '{8};
    run(100, 0, 2, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.rq_req = 2'b00;
    @(negedge clk);
    check_outputs_zero("midreset");
    sbq.delete();
    gq.delete();
    bl0.delete();
    bl1.delete();
    mptr = 0;
    stat_m = '{0, 0};
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_valid", 32'(bus.rq_valid), 0);
    end

    // memory not ready with both requesting, then 40/25 beats
    setup(14'h0800, 14'h1800);
    bl0 = '{16, 16, 8};
    bl1 = '{9, 16};
    run(100, 6, 0, 1'b1);
    check("total_beats0", stat_m[0], 40);
    check("total_beats1", stat_m[1], 25);
`ifdef GRAY_MEM_ARB_STATS_EN
    check("stat_beats0_40", 32'(stat_beats0), 40);
    check("stat_beats1_25", 32'(stat_beats1), 25);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
